// File: rtl/pam_symbol_framer_ctrl_if.sv
// Byte hand-off channel between the PAM symbol framer and its downstream consumer.
// The framer drives data/valid as master; the consumer returns ready as slave.
interface pam_symbol_framer_ctrl_if;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready;

   modport master (
      output byte_data,
      output byte_valid,
      input  byte_ready
   );

   modport slave (
      input  byte_data,
      input  byte_valid,
      output byte_ready
   );
endinterface

// File: rtl/pam_symbol_framer_ctrl.sv
// Symbol-timing strobe, preamble hunt and payload byte packer that sits after the PAM demodulator.
// Packed bytes leave over a valid/ready channel; bytes that find the slot occupied are dropped and flagged.
module pam_symbol_framer_ctrl #(
   parameter int         SYMBOL_LEN   = 16,
   parameter int         SAMPLE_OFS   = 12,
   parameter logic [1:0] PREAMBLE_SYM = 2'd3,
   parameter int         PREAMBLE_CNT = 4,
   parameter int         FRAME_BYTES  = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            i_enable,
   input  logic [1:0]                      i_data_demod,
   pam_symbol_framer_ctrl_if.master        bus,
   output logic                            o_frame_done,
   output logic                            o_overflow,
   output logic                            o_sample_strobe,
   output logic [1:0]                      o_state
);

   localparam int SYM_W   = (SYMBOL_LEN > 1) ? $clog2(SYMBOL_LEN) : 1;
   localparam int MATCH_W = $clog2(PREAMBLE_CNT + 1);
   localparam int BYTE_W  = $clog2(FRAME_BYTES + 1);

   localparam logic [SYM_W-1:0]   SYM_LAST   = SYM_W'(SYMBOL_LEN - 1);
   localparam logic [SYM_W-1:0]   SAMPLE_AT  = SYM_W'(SAMPLE_OFS);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(PREAMBLE_CNT - 1);
   localparam logic [BYTE_W-1:0]  BYTE_LAST  = BYTE_W'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HUNT    = 2'd1,
      S_PAYLOAD = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [SYM_W-1:0]     r_sym_cnt;
   logic [MATCH_W-1:0]   r_match_cnt;
   logic [5:0]           r_shift;
   logic [1:0]           r_sym_idx;
   logic [BYTE_W-1:0]    r_byte_cnt;
   logic [7:0]           r_byte_data;
   logic                 r_byte_valid;
   logic                 r_frame_done;
   logic                 r_overflow;

   logic                 w_strobe;
   logic                 w_hunt_smp;
   logic                 w_pay_smp;
   logic                 w_pre_hit;
   logic                 w_lock;
   logic                 w_byte_done;
   logic                 w_frame_end;
   logic                 w_slot_free;
   logic                 w_load;
   logic                 w_drop;

   assign w_strobe    = (r_sym_cnt == SAMPLE_AT) && i_enable && (r_state != S_IDLE);
   assign w_hunt_smp  = w_strobe && (r_state == S_HUNT);
   assign w_pay_smp   = w_strobe && (r_state == S_PAYLOAD);
   assign w_pre_hit   = (i_data_demod == PREAMBLE_SYM);
   assign w_lock      = w_hunt_smp && w_pre_hit && (r_match_cnt == MATCH_LAST);
   assign w_byte_done = w_pay_smp && (r_sym_idx == 2'd3);
   assign w_frame_end = w_byte_done && (r_byte_cnt == BYTE_LAST);

   // A consume in the same cycle frees the slot, so the new byte wins over the clear.
   assign w_slot_free = !r_byte_valid || bus.byte_ready;
   assign w_load      = w_byte_done && w_slot_free;
   assign w_drop      = w_byte_done && !w_slot_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!i_enable) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    w_state_nxt = S_HUNT;
            S_HUNT:    if (w_lock) w_state_nxt = S_PAYLOAD;
            S_PAYLOAD: if (w_frame_end) w_state_nxt = S_HUNT;
            default:   w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Symbol timing, preamble matching and payload packing; all cleared when disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sym_cnt   <= '0;
         r_match_cnt <= '0;
         r_shift     <= '0;
         r_sym_idx   <= '0;
         r_byte_cnt  <= '0;
      end else if (!i_enable) begin
         r_sym_cnt   <= '0;
         r_match_cnt <= '0;
         r_shift     <= '0;
         r_sym_idx   <= '0;
         r_byte_cnt  <= '0;
      end else begin
         r_sym_cnt <= (r_sym_cnt == SYM_LAST) ? '0 : r_sym_cnt + 1'b1;

         if (w_hunt_smp) begin
            r_match_cnt <= (w_pre_hit && !w_lock) ? r_match_cnt + 1'b1 : '0;
         end

         // Only the last three symbols are kept; the fourth is taken straight from the input.
         if (w_pay_smp) begin
            r_shift   <= {r_shift[3:0], i_data_demod};
            r_sym_idx <= r_sym_idx + 2'd1;
         end

         if (w_byte_done) begin
            r_byte_cnt <= w_frame_end ? '0 : r_byte_cnt + 1'b1;
         end
      end
   end

   // Output slot survives a disable so an unconsumed byte is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_byte_data  <= '0;
         r_byte_valid <= 1'b0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_load) begin
            r_byte_data  <= {r_shift, i_data_demod};
            r_byte_valid <= 1'b1;
         end else if (bus.byte_ready) begin
            r_byte_valid <= 1'b0;
         end

         if (w_drop) begin
            r_overflow <= 1'b1;
         end

         r_frame_done <= w_frame_end;
      end
   end

   assign bus.byte_data   = r_byte_data;
   assign bus.byte_valid  = r_byte_valid;
   assign o_frame_done    = r_frame_done;
   assign o_overflow      = r_overflow;
   assign o_sample_strobe = w_strobe;
   assign o_state         = r_state;

endmodule

// File: tb/tb_pam_symbol_framer_ctrl.sv
// Directed bench for the PAM symbol framer: expected bytes are queued by the stimulus
// and a negedge monitor pops and compares them on every accepted handshake.
module tb_pam_symbol_framer_ctrl;

   localparam int SYMBOL_LEN   = 16;
   localparam int SAMPLE_OFS   = 12;
   localparam int PREAMBLE_CNT = 4;
   localparam int FRAME_BYTES  = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [1:0] data_demod = 2'd0;
   logic       frame_done;
   logic       overflow;
   logic       sample_strobe;
   logic [1:0] state_o;

   pam_symbol_framer_ctrl_if bus ();

   pam_symbol_framer_ctrl #(
      .SYMBOL_LEN   (SYMBOL_LEN),
      .SAMPLE_OFS   (SAMPLE_OFS),
      .PREAMBLE_SYM (2'd3),
      .PREAMBLE_CNT (PREAMBLE_CNT),
      .FRAME_BYTES  (FRAME_BYTES)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_enable        (enable),
      .i_data_demod    (data_demod),
      .bus             (bus),
      .o_frame_done    (frame_done),
      .o_overflow      (overflow),
      .o_sample_strobe (sample_strobe),
      .o_state         (state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       fd;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   int   fd_count = 0;

   task automatic chk1(input string n, input logic a, input logic e);
      n_checks++;
      if (a !== e) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", n, a, e);
      end
   endtask

   task automatic chk2(input string n, input logic [1:0] a, input logic [1:0] e);
      n_checks++;
      if (a !== e) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask

   task automatic chk8(input string n, input logic [7:0] a, input logic [7:0] e);
      n_checks++;
      if (a !== e) begin
         n_errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", n, a, e);
      end
   endtask

   task automatic chki(input string n, input int a, input int e);
      n_checks++;
      if (a != e) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input logic fd);
      exp_t e;
      e.data = d;
      e.fd   = fd;
      sb_q.push_back(e);
   endtask

   // Holds one symbol on data_demod for ncyc clocks, returning just after a rising edge.
   task automatic run_sym(input logic [1:0] s, input int ncyc);
      data_demod = s;
      repeat (ncyc) @(posedge clk);
      #1;
   endtask

   // Sends n whole symbol periods, first symbol taken from the most significant pair of v.
   task automatic send(input logic [31:0] v, input int n);
      for (int k = 0; k < n; k++) begin
         run_sym(v[2*(n-1-k) +: 2], SYMBOL_LEN);
      end
   endtask

   task automatic go_idle();
      enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk2("idle_state", state_o, 2'd0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_count++;
      if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_byte: got 0x%02h expected no byte", bus.byte_data);
         end else begin
            mon_e = sb_q.pop_front();
            chk8("byte_data", bus.byte_data, mon_e.data);
            chk1("frame_done_with_byte", frame_done, mon_e.fd);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.byte_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk1("rst_valid", bus.byte_valid, 1'b0);
      chk8("rst_data", bus.byte_data, 8'h00);
      chk1("rst_frame_done", frame_done, 1'b0);
      chk1("rst_overflow", overflow, 1'b0);
      chk1("rst_strobe", sample_strobe, 1'b0);
      chk2("rst_state", state_o, 2'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Lock and pack: 3,3,3,3 | 1,2,3,0 | 2,2,1,1
      enable = 1'b1;
      push_exp(8'h6C, 1'b0);
      push_exp(8'hA5, 1'b1);
      send(32'h3, 1);
      @(negedge clk);
      chk2("t1_hunting", state_o, 2'd1);
      send(32'h3F, 3);
      @(negedge clk);
      chk2("t1_locked", state_o, 2'd2);
      send(32'h6CA5, 8);
      @(negedge clk);
      chk2("t1_back_to_hunt", state_o, 2'd1);
      chki("t1_frame_count", fd_count, 1);
      chk1("t1_no_overflow", overflow, 1'b0);
      go_idle();

      // Broken preamble: 3,3,3,1 then a clean preamble, payload 0x01, 0xFF
      enable = 1'b1;
      push_exp(8'h01, 1'b0);
      push_exp(8'hFF, 1'b1);
      send(32'hFD, 4);
      @(negedge clk);
      chk2("t2_not_locked", state_o, 2'd1);
      send(32'hFF, 4);
      @(negedge clk);
      chk2("t2_locked", state_o, 2'd2);
      send(32'h01FF, 8);
      @(negedge clk);
      chk2("t2_back_to_hunt", state_o, 2'd1);
      chki("t2_frame_count", fd_count, 2);
      go_idle();

      // Backpressure for the whole frame
      bus.byte_ready = 1'b0;
      enable = 1'b1;
      push_exp(8'h6C, 1'b0);
      send(32'hFF6C, 8);
      @(negedge clk);
      chk1("t3_first_valid", bus.byte_valid, 1'b1);
      chk8("t3_first_data", bus.byte_data, 8'h6C);
      chk1("t3_no_overflow_yet", overflow, 1'b0);
      send(32'hA5, 4);
      @(negedge clk);
      chk1("t3_still_valid", bus.byte_valid, 1'b1);
      chk8("t3_data_stable", bus.byte_data, 8'h6C);
      chk1("t3_overflow", overflow, 1'b1);
      chk2("t3_back_to_hunt", state_o, 2'd1);
      chki("t3_frame_count", fd_count, 3);
      @(posedge clk);
      #1 bus.byte_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk1("t3_valid_cleared", bus.byte_valid, 1'b0);
      chk1("t3_overflow_sticky", overflow, 1'b1);
      go_idle();
      @(negedge clk);
      chk1("t3_overflow_after_idle", overflow, 1'b1);
      @(posedge clk);
      #1;

      // Asynchronous reset mid-symbol while a byte is held
      bus.byte_ready = 1'b0;
      enable = 1'b1;
      send(32'hFF6C, 8);
      @(negedge clk);
      chk1("t6_held_before_reset", bus.byte_valid, 1'b1);
      chk2("t6_payload_before_reset", state_o, 2'd2);
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk1("t6_valid", bus.byte_valid, 1'b0);
      chk8("t6_data", bus.byte_data, 8'h00);
      chk1("t6_overflow", overflow, 1'b0);
      chk1("t6_frame_done", frame_done, 1'b0);
      chk1("t6_strobe", sample_strobe, 1'b0);
      chk2("t6_state", state_o, 2'd0);
      enable = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Consume and load in the same strobe cycle
      enable = 1'b1;
      push_exp(8'h6C, 1'b0);
      push_exp(8'hA5, 1'b0);
      send(32'hFF6C, 8);
      send(32'h29, 3);
      run_sym(2'b01, SAMPLE_OFS);
      bus.byte_ready = 1'b1;
      @(negedge clk);
      chk1("t4_strobe", sample_strobe, 1'b1);
      chk1("t4_valid_in_strobe", bus.byte_valid, 1'b1);
      @(posedge clk);
      #1 bus.byte_ready = 1'b0;
      @(negedge clk);
      chk1("t4_valid_after", bus.byte_valid, 1'b1);
      chk8("t4_new_data", bus.byte_data, 8'hA5);
      chk1("t4_no_overflow", overflow, 1'b0);
      chk1("t4_frame_done", frame_done, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk2("t4_back_to_hunt", state_o, 2'd1);
      chki("t4_frame_count", fd_count, 4);
      @(posedge clk);
      #1 bus.byte_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk1("t4_drained", bus.byte_valid, 1'b0);
      go_idle();

      // Disable during payload after two symbols, then re-hunt from scratch
      enable = 1'b1;
      push_exp(8'h01, 1'b0);
      push_exp(8'hAA, 1'b1);
      send(32'hFF6, 6);
      @(negedge clk);
      chk2("t5_in_payload", state_o, 2'd2);
      enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk2("t5_dropped_to_idle", state_o, 2'd0);
      chk1("t5_no_byte", bus.byte_valid, 1'b0);
      @(posedge clk);
      #1 enable = 1'b1;
      send(32'h3F, 3);
      @(negedge clk);
      chk2("t5_rehunt_not_locked", state_o, 2'd1);
      send(32'h3, 1);
      @(negedge clk);
      chk2("t5_relocked", state_o, 2'd2);
      send(32'h01AA, 8);
      @(negedge clk);
      chk2("t5_back_to_hunt", state_o, 2'd1);
      chki("t5_frame_count", fd_count, 5);
      go_idle();

      repeat (4) @(posedge clk);
      @(negedge clk);
      chki("scoreboard_empty", sb_q.size(), 0);
      chki("final_frame_count", fd_count, 5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pam_symbol_framer_ctrl.md
Name: pam_symbol_framer_ctrl

Overview:
- Sequencing controller placed after the PAM demodulator.
- Generates the symbol-timing sample strobe and samples the 2-bit demodulated symbol once per symbol period, after the moving-average filter has settled.
- Hunts for a preamble, then packs payload symbols into bytes and hands them downstream over a valid/ready interface, one frame at a time.

Parameters:
- SYMBOL_LEN, 16, clocks per symbol period (>=2).
- SAMPLE_OFS, 12, sym_cnt value at which data_demod is sampled (0..SYMBOL_LEN-1); covers filter latency.
- PREAMBLE_SYM, 2'd3, symbol value that forms the preamble.
- PREAMBLE_CNT, 4, consecutive PREAMBLE_SYM samples required to lock (>=1).
- FRAME_BYTES, 4, payload bytes per frame (>=1).

Ports:
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  run control; rising edge must coincide with a symbol boundary
- data_demod  input  2  symbol from the PAM demodulator
- byte_ready  input  1  downstream accepts byte_data when high with byte_valid
- byte_data  output  8  packed payload byte, first symbol in bits [7:6]
- byte_valid  output  1  byte_data holds an unconsumed byte
- frame_done  output  1  one-cycle pulse when the last byte of a frame is packed
- overflow  output  1  sticky flag: a packed byte was dropped
- sample_strobe  output  1  high in the cycle data_demod is sampled
- state_o  output  2  current state: 0 IDLE, 1 HUNT, 2 PAYLOAD

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, sym_cnt 0, match count 0, shift register 0, symbol index 0, byte count 0. All outputs 0.
- sym_cnt is free-running 0..SYMBOL_LEN-1 while enable=1 and wraps to 0. It is held at 0 while enable=0.
- sample_strobe is combinational: (sym_cnt==SAMPLE_OFS) && enable && state!=IDLE. The first strobe occurs SAMPLE_OFS cycles after enable rises.
- IDLE -> HUNT on the first cycle enable=1. From any state, enable=0 -> IDLE next cycle; this clears sym_cnt, match count, shift register, symbol index and byte count. byte_valid/byte_data are held until consumed. overflow is cleared only by reset.
- HUNT, on each strobe:
  - data_demod==PREAMBLE_SYM: match count +1. If it reaches PREAMBLE_CNT, go to PAYLOAD and clear match count.
  - Any other value: match count cleared to 0.
- PAYLOAD, on each strobe:
  - shift <= {shift[5:0], data_demod}; symbol index +1 (mod 4).
  - On the 4th symbol, the completed byte is {shift[5:0], data_demod}.
  - If the output slot is free (byte_valid==0, or byte_valid && byte_ready in the same cycle), load byte_data and set byte_valid. Otherwise drop the byte and set overflow.
  - byte_valid and byte_data are visible the cycle after the strobe.
  - The byte counter increments whether the byte was delivered or dropped.
- When the byte counter reaches FRAME_BYTES: frame_done pulses in the cycle after that strobe, byte count resets to 0, and state returns to HUNT.
- Handshake: byte_valid stays high and byte_data stays stable until a cycle with byte_ready=1, which clears byte_valid at the next edge. If a load and a consume fall in the same cycle, the load wins: byte_valid stays 1 with the new data.
- data_demod is ignored outside strobe cycles. No preamble check happens inside PAYLOAD, so preamble-valued payload symbols are legal data.
- Reset asserted mid-frame aborts immediately. No partial byte is emitted.

Test Plan:
Common setup: SYMBOL_LEN=16, SAMPLE_OFS=12, PREAMBLE_CNT=4, FRAME_BYTES=2, byte_ready=1 unless stated.
- Lock and pack: enable at cycle 0, symbols 3,3,3,3 then 1,2,3,0, 2,2,1,1 -> strobes at cycles 12,28,44,…
  - state_o=2 after the 4th strobe.
  - byte_valid pulses with 0x6C, then 0xA5.
  - frame_done pulses together with the second byte.
  - state_o returns to 1.
- Broken preamble: symbols 3,3,3,1,3,3,3,3,0,0,0,1 -> lock only after the 8th symbol; first byte 0x01.
- Backpressure: byte_ready=0 throughout the frame -> first byte 0x6C held stable, second byte dropped, overflow=1 and stays 1. Raising byte_ready clears byte_valid next cycle.
- Same-cycle consume and load: byte_ready asserted exactly in the strobe cycle completing byte 2 -> no overflow; byte_data becomes 0xA5 with byte_valid continuously 1.
- enable dropped during PAYLOAD after 2 symbols -> state_o=0 next cycle, no byte produced. Re-enable re-hunts from match count 0.
- rst_n pulsed low mid-symbol -> all outputs 0 asynchronously, before the next clk edge.
